// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and window helpers used by the timing
// generator and the downstream colour stage.
package vga_timing_pkg;

    localparam int COUNT_W = 10;
    localparam int DIV_W   = 4;

    localparam int VGA_CLK_DIV     = 4;
    localparam int VGA_H_TOTAL     = 800;
    localparam int VGA_H_SYNC      = 96;
    localparam int VGA_H_ACT_START = 144;
    localparam int VGA_H_ACT_END   = 783;
    localparam int VGA_V_TOTAL     = 525;
    localparam int VGA_V_SYNC      = 2;
    localparam int VGA_V_ACT_START = 35;
    localparam int VGA_V_ACT_END   = 514;

    // Inclusive range test on a raster coordinate.
    function automatic logic in_window(input logic [COUNT_W-1:0] val,
                                       input logic [COUNT_W-1:0] lo,
                                       input logic [COUNT_W-1:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_pix_en_div.sv
// Pixel-rate enable: pulses tick once every CLK_DIV enabled Clk cycles and
// holds its phase while En is low so no pixel is skipped or doubled.
module pix_en_div
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = VGA_CLK_DIV
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic En,
    output logic tick
);

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;

    // tick stays combinational so the counters and pixTick register on this edge
    always_comb begin
        tick = En && (div_cnt_q == DIV_MAX);
        if (tick) begin
            div_cnt_d = {DIV_W{1'b0}};
        end else if (En) begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end else begin
            div_cnt_d = div_cnt_q;
        end
    end

    // Divider phase register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            div_cnt_q <= {DIV_W{1'b0}};
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: horizontal/vertical counters with sync, visible-window
// and frame markers, all registered together with zero skew to the counts.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV     = VGA_CLK_DIV,
    parameter int H_TOTAL     = VGA_H_TOTAL,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_ACT_START = VGA_H_ACT_START,
    parameter int H_ACT_END   = VGA_H_ACT_END,
    parameter int V_TOTAL     = VGA_V_TOTAL,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_ACT_START = VGA_V_ACT_START,
    parameter int V_ACT_END   = VGA_V_ACT_END
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               En,
    output logic               hSync,
    output logic               vSync,
    output logic               Bright,
    output logic [COUNT_W-1:0] hCount,
    output logic [COUNT_W-1:0] vCount,
    output logic               pixTick,
    output logic               frameStart
);

    localparam logic [COUNT_W-1:0] H_MAX = COUNT_W'(H_TOTAL - 1);
    localparam logic [COUNT_W-1:0] V_MAX = COUNT_W'(V_TOTAL - 1);
    localparam logic [COUNT_W-1:0] H_SW  = COUNT_W'(H_SYNC);
    localparam logic [COUNT_W-1:0] V_SW  = COUNT_W'(V_SYNC);
    localparam logic [COUNT_W-1:0] H_AS  = COUNT_W'(H_ACT_START);
    localparam logic [COUNT_W-1:0] H_AE  = COUNT_W'(H_ACT_END);
    localparam logic [COUNT_W-1:0] V_AS  = COUNT_W'(V_ACT_START);
    localparam logic [COUNT_W-1:0] V_AE  = COUNT_W'(V_ACT_END);

    logic               tick_s;
    logic               h_wrap_s;
    logic               v_wrap_s;
    logic [COUNT_W-1:0] h_count_q, h_count_d;
    logic [COUNT_W-1:0] v_count_q, v_count_d;
    logic               h_sync_q, h_sync_d;
    logic               v_sync_q, v_sync_d;
    logic               bright_q, bright_d;
    logic               pix_tick_q, pix_tick_d;
    logic               frame_start_q, frame_start_d;

    pix_en_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_en_div (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .En    (En),
        .tick  (tick_s)
    );

    // Next raster position; >= keeps any out-of-range count folding back to 0.
    always_comb begin
        h_wrap_s = (h_count_q >= H_MAX);
        v_wrap_s = (v_count_q >= V_MAX);
        h_count_d = h_count_q;
        v_count_d = v_count_q;
        if (tick_s) begin
            if (h_wrap_s) begin
                h_count_d = {COUNT_W{1'b0}};
                if (v_wrap_s) begin
                    v_count_d = {COUNT_W{1'b0}};
                end else begin
                    v_count_d = v_count_q + COUNT_W'(1);
                end
            end else begin
                h_count_d = h_count_q + COUNT_W'(1);
                v_count_d = v_count_q;
            end
        end else begin
            h_count_d = h_count_q;
            v_count_d = v_count_q;
        end
    end

    // Decode from the next position so flags line up with the registered counts.
    always_comb begin
        h_sync_d      = (h_count_d >= H_SW);
        v_sync_d      = (v_count_d >= V_SW);
        bright_d      = in_window(h_count_d, H_AS, H_AE) && in_window(v_count_d, V_AS, V_AE);
        pix_tick_d    = tick_s;
        frame_start_d = tick_s && h_wrap_s && v_wrap_s;
    end

    // Output and counter registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            h_count_q     <= {COUNT_W{1'b0}};
            v_count_q     <= {COUNT_W{1'b0}};
            h_sync_q      <= 1'b0;
            v_sync_q      <= 1'b0;
            bright_q      <= 1'b0;
            pix_tick_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_count_q     <= h_count_d;
            v_count_q     <= v_count_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            bright_q      <= bright_d;
            pix_tick_q    <= pix_tick_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hCount     = h_count_q;
    assign vCount     = v_count_q;
    assign hSync      = h_sync_q;
    assign vSync      = v_sync_q;
    assign Bright     = bright_q;
    assign pixTick    = pix_tick_q;
    assign frameStart = frame_start_q;

endmodule
